// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - frame layout constants, FSM states and frame builder shared by spi_master
package spi_pkg;

   localparam int FRAME_BITS      = 16;
   localparam int RDATA_FIRST_BIT = 8;

   localparam int MODE_BIT = 15;
   localparam int ADDR_MSB = 14;
   localparam int ADDR_LSB = 11;
   localparam int DATA_MSB = 7;

   localparam logic MODE_READ  = 1'b1;
   localparam logic MODE_WRITE = 1'b0;

   typedef enum logic [2:0] {
      FLUSH,
      IDLE,
      LOW,
      HIGH,
      GAP
   } spi_state_t;

   // Reads carry zeros in the data field; bits 10:8 are always zero.
   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic       rw,
      input logic [3:0] addr,
      input logic [7:0] wdata
   );
      logic [FRAME_BITS-1:0] f;
      f                    = '0;
      f[MODE_BIT]          = rw;
      f[ADDR_MSB:ADDR_LSB] = addr;
      if (rw == MODE_WRITE) begin
         f[DATA_MSB:0] = wdata;
      end
      return f;
   endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// rtl/spi_phase_timer.sv - CLKDIV down-counter giving a one-cycle tick at the end of each phase
module spi_phase_timer #(
   parameter int CLKDIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic reload,
   output logic tick
);

   localparam logic [7:0] LOAD = 8'(CLKDIV - 1);

   logic [7:0] cnt;

   // Auto-reloads on every tick so consecutive phases stay exactly CLKDIV long.
   always_ff @(posedge clk) begin
      if (reset || reload) begin
         cnt <= LOAD;
      end else if (cnt == 8'd0) begin
         cnt <= LOAD;
      end else begin
         cnt <= cnt - 8'd1;
      end
   end

   assign tick = (cnt == 8'd0);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - 16-bit SPI read/write master generating spiclk/spien/MOSI from clk
module spi_master
   import spi_pkg::*;
#(
   parameter int CLKDIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rw,
   input  logic [3:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       spiclk,
   output logic       spien,
   output logic       spidout,
   input  logic       spidin
);

   localparam logic [3:0] RD_FIRST = 4'(RDATA_FIRST_BIT);
   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

   spi_state_t state, state_n;

   logic        spiclk_n, spien_n, spidout_n, done_n, busy_n;
   logic [7:0]  rdata_n;
   logic [14:0] tx, tx_n;
   logic [7:0]  rx, rx_n;
   logic [3:0]  bitcnt, bitcnt_n;
   logic        is_read, is_read_n;
   logic        armed, armed_n;
   logic        reload, tick;
   logic [FRAME_BITS-1:0] frame_w;

   spi_phase_timer #(
      .CLKDIV(CLKDIV)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .reload (reload),
      .tick   (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FLUSH;
         spiclk  <= 1'b0;
         spien   <= 1'b0;
         spidout <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b1;
         rdata   <= 8'h00;
         tx      <= '0;
         rx      <= 8'h00;
         bitcnt  <= 4'd0;
         is_read <= 1'b0;
         armed   <= 1'b0;
      end else begin
         state   <= state_n;
         spiclk  <= spiclk_n;
         spien   <= spien_n;
         spidout <= spidout_n;
         done    <= done_n;
         busy    <= busy_n;
         rdata   <= rdata_n;
         tx      <= tx_n;
         rx      <= rx_n;
         bitcnt  <= bitcnt_n;
         is_read <= is_read_n;
         armed   <= armed_n;
      end
   end

   always_comb begin
      state_n   = state;
      spiclk_n  = spiclk;
      spien_n   = spien;
      spidout_n = spidout;
      done_n    = 1'b0;
      busy_n    = busy;
      rdata_n   = rdata;
      tx_n      = tx;
      rx_n      = rx;
      bitcnt_n  = bitcnt;
      is_read_n = is_read;
      armed_n   = armed;
      reload    = 1'b0;
      frame_w   = build_frame(rw, addr, wdata);

      case (state)
         // One spiclk pulse with spien low resynchronises the slave's bit counter.
         FLUSH: begin
            if (!armed) begin
               spiclk_n = 1'b1;
               armed_n  = 1'b1;
               reload   = 1'b1;
            end else if (tick) begin
               if (spiclk) begin
                  spiclk_n = 1'b0;
               end else begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
               end
            end
         end
         IDLE: begin
            if (start) begin
               tx_n      = frame_w[FRAME_BITS-2:0];
               spidout_n = frame_w[MODE_BIT];
               is_read_n = (rw == MODE_READ);
               spien_n   = 1'b1;
               spiclk_n  = 1'b0;
               busy_n    = 1'b1;
               bitcnt_n  = 4'd0;
               reload    = 1'b1;
               state_n   = LOW;
            end
         end
         LOW: begin
            if (tick) begin
               spiclk_n = 1'b1;
               if (bitcnt >= RD_FIRST) begin
                  rx_n = {rx[6:0], spidin};
               end
               state_n = HIGH;
            end
         end
         HIGH: begin
            if (tick) begin
               spiclk_n = 1'b0;
               if (bitcnt != LAST_BIT) begin
                  bitcnt_n  = bitcnt + 4'd1;
                  spidout_n = tx[14];
                  tx_n      = {tx[13:0], 1'b0};
                  state_n   = LOW;
               end else begin
                  spien_n   = 1'b0;
                  spidout_n = 1'b0;
                  state_n   = GAP;
               end
            end
         end
         GAP: begin
            if (tick) begin
               done_n  = 1'b1;
               busy_n  = 1'b0;
               if (is_read) begin
                  rdata_n = rx;
               end
               state_n = IDLE;
            end
         end
         default: begin
            state_n = FLUSH;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master with a behavioural SPI slave
module tb_spi_master;
   import spi_pkg::*;

   typedef struct {
      logic        rw;
      logic [3:0]  addr;
      logic [7:0]  wdata;
      logic [7:0]  slv_rd;
      logic [15:0] exp_frame;
      logic [7:0]  exp_rdata;
   } vec_t;

   typedef struct {
      logic [15:0] frame;
      logic [7:0]  rdata;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start_a, start_b, rw;
   logic [3:0] addr;
   logic [7:0] wdata;
   logic       busy_a, done_a, spiclk_a, spien_a, spidout_a;
   logic       busy_b, done_b, spiclk_b, spien_b, spidout_b;
   logic [7:0] rdata_a, rdata_b;
   logic       spidin_a = 1'b0;
   logic       spidin_b = 1'b0;

   spi_master #(.CLKDIV(4)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .rw(rw), .addr(addr), .wdata(wdata),
      .busy(busy_a), .done(done_a), .rdata(rdata_a), .spiclk(spiclk_a), .spien(spien_a),
      .spidout(spidout_a), .spidin(spidin_a)
   );

   spi_master #(.CLKDIV(1)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .rw(rw), .addr(addr), .wdata(wdata),
      .busy(busy_b), .done(done_b), .rdata(rdata_b), .spiclk(spiclk_b), .spien(spien_b),
      .spidout(spidout_b), .spidin(spidin_b)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave models: sample MOSI on rising spiclk, launch read byte on falling edges 8..15.
   logic [7:0]  rddata_a = 8'h00, rddata_b = 8'h00;
   logic [15:0] srx_a = '0, sframe_a = '0, srx_b = '0, sframe_b = '0;
   int sbit_a = 0, nframes_a = 0, rise_en_a = 0, rise_dis_a = 0;
   int sbit_b = 0, nframes_b = 0;

   always @(posedge spiclk_a) begin
      if (!spien_a) begin
         sbit_a = 0;
         rise_dis_a++;
      end else begin
         srx_a = {srx_a[14:0], spidout_a};
         sbit_a++;
         rise_en_a++;
         if (sbit_a == FRAME_BITS) begin
            sframe_a = srx_a;
            nframes_a++;
            sbit_a = 0;
         end
      end
   end

   always @(negedge spiclk_a)
      if (spien_a && sbit_a >= 8) spidin_a = rddata_a[15 - sbit_a];

   always @(posedge spiclk_b) begin
      if (!spien_b) begin
         sbit_b = 0;
      end else begin
         srx_b = {srx_b[14:0], spidout_b};
         sbit_b++;
         if (sbit_b == FRAME_BITS) begin
            sframe_b = srx_b;
            nframes_b++;
            sbit_b = 0;
         end
      end
   end

   always @(negedge spiclk_b)
      if (spien_b && sbit_b >= 8) spidin_b = rddata_b[15 - sbit_b];

   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];
   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic score_a(input string tag);
      exp_t e;
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: done with empty scoreboard", tag);
      end else begin
         e = sbq.pop_front();
         check({tag, " frame"}, sframe_a, e.frame);
         check({tag, " rdata"}, rdata_a, e.rdata);
      end
   endtask

   task automatic run_a(input string tag, input vec_t v);
      int   lat, fr0, re0;
      exp_t e;
      @(negedge clk);
      check({tag, " idle"}, busy_a, 0);
      rw = v.rw; addr = v.addr; wdata = v.wdata; rddata_a = v.slv_rd; start_a = 1'b1;
      e.frame = v.exp_frame;
      e.rdata = v.exp_rdata;
      sbq.push_back(e);
      fr0 = nframes_a;
      re0 = rise_en_a;
      @(negedge clk);
      start_a = 1'b0;
      check({tag, " E0 outputs"}, {busy_a, spien_a, spiclk_a, spidout_a},
            {1'b1, 1'b1, 1'b0, v.exp_frame[15]});
      lat = 0;
      while (!done_a && lat < 1000) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, lat, 132);
      check({tag, " frames"}, nframes_a - fr0, 1);
      check({tag, " rises"}, rise_en_a - re0, 16);
      score_a(tag);
   endtask

   task automatic flush_check(input string tag);
      int   n, r0;
      logic saw_done, saw_en;
      n = 0; r0 = rise_dis_a; saw_done = 1'b0; saw_en = 1'b0;
      do begin
         @(negedge clk);
         if (busy_a) n++;
         saw_done |= done_a;
         saw_en   |= spien_a;
      end while (busy_a && n < 100);
      check({tag, " busy cycles"}, n, 8);
      check({tag, " pulses"}, rise_dis_a - r0, 1);
      check({tag, " no done"}, saw_done, 0);
      check({tag, " spien low"}, saw_en, 0);
   endtask

   initial begin
      int   n, re0, fr0, t1;
      exp_t e;
      vec_t v;

      vecs[0] = '{1'b0, 4'h5, 8'hA3, 8'h00, 16'h28A3, 8'h00};
      vecs[1] = '{1'b1, 4'hC, 8'h00, 8'h5E, 16'hE000, 8'h5E};
      vecs[2] = '{1'b0, 4'hF, 8'hFF, 8'h33, 16'h78FF, 8'h5E};
      vecs[3] = '{1'b1, 4'h7, 8'h55, 8'hAA, 16'hB800, 8'hAA};
      vecs[4] = '{1'b1, 4'h0, 8'h00, 8'h01, 16'h8000, 8'h01};
      vecs[5] = '{1'b0, 4'h0, 8'h00, 8'h00, 16'h0000, 8'h01};

      reset = 1'b1; start_a = 1'b0; start_b = 1'b0; rw = 1'b0; addr = 4'h0; wdata = 8'h00;
      repeat (3) @(negedge clk);
      check("reset outputs", {spiclk_a, spien_a, spidout_a, done_a, busy_a}, 5'b00001);
      check("reset rdata", rdata_a, 8'h00);
      reset = 1'b0;
      flush_check("flush");

      for (int i = 0; i < 6; i++) run_a($sformatf("vec%0d", i), vecs[i]);

      // Reset after rising edge 7 of a frame.
      @(negedge clk);
      rw = 1'b0; addr = 4'h6; wdata = 8'h99; start_a = 1'b1;
      re0 = rise_en_a;
      @(negedge clk);
      start_a = 1'b0;
      n = 0;
      while (rise_en_a - re0 < 7 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("midrst edge7", rise_en_a - re0, 7);
      reset = 1'b1;
      fr0 = nframes_a;
      @(negedge clk);
      check("midrst outputs", {spiclk_a, spien_a, spidout_a, done_a, busy_a}, 5'b00001);
      check("midrst rdata", rdata_a, 8'h00);
      reset = 1'b0;
      flush_check("midrst flush");
      check("midrst no frame", nframes_a - fr0, 0);
      v = '{1'b0, 4'h3, 8'h0F, 8'h00, 16'h180F, 8'h00};
      run_a("after reset", v);

      // Start held high: second frame follows after GAP plus the done cycle.
      @(negedge clk);
      rw = 1'b0; addr = 4'h2; wdata = 8'h3C; start_a = 1'b1;
      e.frame = 16'h103C; e.rdata = 8'h00; sbq.push_back(e);
      repeat (40) @(negedge clk);
      check("b2b busy mid", busy_a, 1);
      addr = 4'h9; wdata = 8'hC3;
      e.frame = 16'h48C3; e.rdata = 8'h00; sbq.push_back(e);
      n = 0;
      while (!done_a && n < 1000) begin
         @(negedge clk);
         n++;
      end
      t1 = cyc;
      score_a("b2b first");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done_a && n < 1000);
      start_a = 1'b0;
      check("b2b spacing", cyc - t1, 133);
      score_a("b2b second");
      repeat (2) @(negedge clk);
      check("b2b idle", busy_a, 0);

      // CLKDIV=1 read.
      @(negedge clk);
      check("div1 idle", busy_b, 0);
      rw = 1'b1; addr = 4'h1; wdata = 8'h7E; rddata_b = 8'h81; start_b = 1'b1;
      fr0 = nframes_b;
      @(negedge clk);
      start_b = 1'b0;
      n = 0;
      while (!done_b && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("div1 latency", n, 33);
      check("div1 frames", nframes_b - fr0, 1);
      check("div1 frame", sframe_b, 16'h8800);
      check("div1 rdata", rdata_b, 8'h81);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
